// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the synchronous FIFO: depth and pointer-width
// helpers plus the per-cycle operation encoding used for count updates.
package sync_fifo_pkg;

  // Number of entries addressed by an ADDR_WIDTH-bit index.
  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Pointers carry one extra wrap bit above the memory index.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  // What the FIFO actually does this cycle: {write accepted, read accepted}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/sync_fifo_chk.sv
// Elaboration-time sanity check on the almost-full / almost-empty levels.
module sync_fifo_chk #(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 1
) ();

  if ((AF_LEVEL < 1) || (AF_LEVEL > (1 << ADDR_WIDTH))) begin : g_af_bad
    $error("sync_fifo: AF_LEVEL=%0d outside 1..DEPTH", AF_LEVEL);
  end

  if ((AE_LEVEL < 0) || (AE_LEVEL > ((1 << ADDR_WIDTH) - 1))) begin : g_ae_bad
    $error("sync_fifo: AE_LEVEL=%0d outside 0..DEPTH-1", AE_LEVEL);
  end

endmodule

// File: rtl/sync_fifo_ram.sv
// FIFO storage: one write port and one registered read port on a single clock.
// The storage array itself is not reset; only the read register is.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_r;

  // Store the incoming word; a same-slot read this cycle still sees old data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; holds its value when no read is performed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {DATA_WIDTH{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, registered occupancy count, level flags,
// sticky error flags and synchronous flush around sync_fifo_ram.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int            PW      = ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0] DEPTH_C = PW'(fifo_depth(ADDR_WIDTH));
  localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);
  localparam logic [PW-1:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [PW-1:0] wptr_r, rptr_r, count_r, count_nx_s;
  logic          rvalid_r, overflow_r, underflow_r;
  logic          full_s, empty_s, rd_acc_s, wr_acc_s, rd_do_s, wr_do_s;
  fifo_op_e      op_s;

  sync_fifo_chk #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .AF_LEVEL   (AF_LEVEL),
    .AE_LEVEL   (AE_LEVEL)
  ) u_chk ();

  // Flags come straight from the count register so they track it same-cycle.
  assign full_s       = (count_r == DEPTH_C);
  assign empty_s      = (count_r == {PW{1'b0}});
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_r >= AF_C);
  assign almost_empty = (count_r <= AE_C);
  assign count        = count_r;
  assign rvalid       = rvalid_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

  // A full FIFO still takes a write when a read frees a slot in the same cycle;
  // an empty FIFO never forwards a same-cycle write to the reader.
  assign rd_acc_s = rd_en & ~empty_s;
  assign wr_acc_s = wr_en & (~full_s | rd_acc_s);
  // Flush suppresses any memory access in its cycle.
  assign rd_do_s  = rd_acc_s & ~flush;
  assign wr_do_s  = wr_acc_s & ~flush;
  assign op_s     = fifo_op_e'({wr_do_s, rd_do_s});

  // Next occupancy: push and pop in one cycle leave it unchanged.
  always_comb begin
    count_nx_s = count_r;
    case (op_s)
      OP_WR:   count_nx_s = count_r + ONE_C;
      OP_RD:   count_nx_s = count_r - ONE_C;
      OP_RW:   count_nx_s = count_r;
      OP_IDLE: count_nx_s = count_r;
      default: count_nx_s = count_r;
    endcase
  end

  // Pointer, count, read-valid and sticky error state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r      <= {PW{1'b0}};
      rptr_r      <= {PW{1'b0}};
      count_r     <= {PW{1'b0}};
      rvalid_r    <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (flush) begin
      wptr_r      <= {PW{1'b0}};
      rptr_r      <= {PW{1'b0}};
      count_r     <= {PW{1'b0}};
      rvalid_r    <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_do_s) begin
        wptr_r <= wptr_r + ONE_C;
      end
      if (rd_do_s) begin
        rptr_r <= rptr_r + ONE_C;
      end
      count_r     <= count_nx_s;
      rvalid_r    <= rd_do_s;
      overflow_r  <= overflow_r  | (wr_en & ~wr_acc_s);
      underflow_r <= underflow_r | (rd_en & ~rd_acc_s);
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_do_s),
    .waddr (wptr_r[ADDR_WIDTH-1:0]),
    .wdata (wdata),
    .re    (rd_do_s),
    .raddr (rptr_r[ADDR_WIDTH-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised + directed bench for sync_fifo with a queue-based reference model
// and a scoreboard monitor that checks every read return independently.
module tb_sync_fifo;

  localparam int DW    = 4;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          rvalid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   count;

  sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wdata(wdata),
    .rd_en(rd_en), .rdata(rdata), .rvalid(rvalid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_q[$];
  bit            m_ovf = 1'b0, m_unf = 1'b0;
  logic [DW-1:0] last_rd = '0;
  int            cyc = 0;
  int            pass_cnt = 0, total_cnt = 0;
  int            max_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard monitor: read data must appear exactly one cycle after acceptance.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      chk("rvalid", int'(rvalid), 1);
      chk("rdata", int'(rdata), int'(exp_q[0].data));
      last_rd = exp_q[0].data;
      exp_q.delete(0);
    end else begin
      chk("rvalid_idle", int'(rvalid), 0);
      chk("rdata_hold", int'(rdata), int'(last_rd));
    end
  end

  task automatic check_flags();
    int n;
    n = model_q.size();
    chk("count", int'(count), n);
    chk("full", int'(full), int'(n == DEPTH));
    chk("empty", int'(empty), int'(n == 0));
    chk("almost_full", int'(almost_full), int'(n >= AF));
    chk("almost_empty", int'(almost_empty), int'(n <= AE));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("underflow", int'(underflow), int'(m_unf));
  endtask

  // One clock of stimulus; the model applies the FIFO rules to its own queue.
  task automatic step(input bit fl, input bit we, input logic [DW-1:0] wd, input bit re);
    bit rd_acc, wr_acc;
    exp_t e;
    @(negedge clk);
    flush = fl; wr_en = we; wdata = wd; rd_en = re;
    if (fl) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      rd_acc = re && (model_q.size() > 0);
      wr_acc = we && ((model_q.size() < DEPTH) || rd_acc);
      if (rd_acc) begin
        e.due  = cyc + 1;
        e.data = model_q.pop_front();
        exp_q.push_back(e);
      end
      if (wr_acc) model_q.push_back(wd);
      if (we && !wr_acc) m_ovf = 1'b1;
      if (re && !rd_acc) m_unf = 1'b1;
    end
    @(posedge clk);
    #1;
    check_flags();
    if (model_q.size() > max_cnt) max_cnt = model_q.size();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_ae"}, int'(almost_empty), 1);
    chk({tag, "_af"}, int'(almost_full), 0);
    chk({tag, "_rvalid"}, int'(rvalid), 0);
    chk({tag, "_rdata"}, int'(rdata), 0);
    chk({tag, "_ovf"}, int'(overflow), 0);
    chk({tag, "_unf"}, int'(underflow), 0);
  endtask

  initial begin
    #1;
    check_reset_outputs("reset");
    #11;
    rst_n = 1'b1;

    // Fill to full, one extra write overflows, drain in order.
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, DW'(i), 1'b0);
    step(1'b0, 1'b1, 4'hF, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b0);

    // Read empty, then simultaneous write+read on empty.
    step(1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b1, 4'hA, 1'b1);
    step(1'b1, 1'b0, 4'h0, 1'b0);

    // Full FIFO with simultaneous write and read; 0xC comes out last.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, DW'(i + 3), 1'b0);
    step(1'b0, 1'b1, 4'hC, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 4'h0, 1'b1);

    // Wrap-around: interleaved write/read pairs, occupancy stays at most 1.
    max_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, DW'(i), 1'b0);
      step(1'b0, 1'b0, 4'h0, 1'b1);
    end
    chk("wrap_max_count", max_cnt, 1);

    // Flush with count=5 and overflow set.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, DW'($urandom_range(0, 15)), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'h0, 1'b1);
    chk("pre_flush_count", int'(count), 5);
    step(1'b1, 1'b1, 4'h7, 1'b1);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 99) < 55),
           DW'($urandom_range(0, 15)), ($urandom_range(0, 99) < 45));
    end

    // Asynchronous reset between clock edges in mid-stream.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, DW'(i + 9), 1'b0);
    step(1'b0, 1'b1, 4'h5, 1'b1);
    #2;
    rst_n = 1'b0;
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_q.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    last_rd = '0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, DW'(i + 1), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
